// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the two-master / one-slave bus.
//   ttype_t     - transfer direction (READ/WRITE)
//   tsize_t     - transfer size encoding
//   arb_state_t - arbiter FSM states
//   SEL_MSB/LSB - address bits that carry the slave select field
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } tsize_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    ERR     = 2'd3
  } arb_state_t;

  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 28;

endpackage

// File: rtl/bus_arbiter_2m1s_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   i_req[1:0] - request vector (bit n = master n)
//   i_last     - index of the master that owned the bus most recently
//   o_gntIdx   - index of the winning master (meaningful when o_any=1)
//   o_any      - at least one request is pending
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gntIdx,
  output logic       o_any
);

  // On a tie the master that did not own the bus last wins; otherwise
  // the lone requester wins (bit 1 set means master 1 is asking).
  always_comb begin
    o_any    = |i_req;
    o_gntIdx = (i_req == 2'b11) ? ~i_last : i_req[1];
  end

endmodule

// File: rtl/bus_arbiter_2m1s.sv
// bus_arbiter_2m1s: shares one slave port between two masters with a
// registered round-robin grant held for a whole transaction.
//   clk, rst_n             - clock (rising edge), async active-low reset
//   i_mN_breq/bstart       - master N bus request / transaction start
//   i_mN_addr/wdata        - master N address and write data
//   i_mN_tsize/ttype       - master N transfer size and direction
//   o_mN_bgnt/bdone/berror - master N grant, completion, error
//   o_mN_rdata             - master N read data
//   o_s0_ss/bstart         - slave select and transaction start
//   o_s0_addr/wdata/tsize/ttype - forwarded owner request fields
//   i_s0_bdone/rdata       - slave completion and read data
// A decode miss or a slave that never answers within TIMEOUT_CYC busy
// cycles ends the transaction with bdone+berror for one cycle.
module bus_arbiter_2m1s
  import bus_pkg::*;
#(
  parameter logic [3:0] SLAVE_SEL   = 4'hF,
  parameter int         TIMEOUT_CYC = 256,
  parameter int         TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_breq,
  input  logic        i_m0_bstart,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [1:0]  i_m0_tsize,
  input  logic        i_m0_ttype,
  output logic        o_m0_bgnt,
  output logic        o_m0_bdone,
  output logic        o_m0_berror,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_breq,
  input  logic        i_m1_bstart,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [1:0]  i_m1_tsize,
  input  logic        i_m1_ttype,
  output logic        o_m1_bgnt,
  output logic        o_m1_bdone,
  output logic        o_m1_berror,
  output logic [31:0] o_m1_rdata,
  output logic        o_s0_ss,
  output logic        o_s0_bstart,
  output logic [31:0] o_s0_addr,
  output logic [31:0] o_s0_wdata,
  output logic [1:0]  o_s0_tsize,
  output logic        o_s0_ttype,
  input  logic        i_s0_bdone,
  input  logic [31:0] i_s0_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_t      r_state, w_nextState;
  logic            r_owner, w_nextOwner;
  logic            r_rrLast, w_nextRrLast;
  logic [TO_W-1:0] r_toCnt, w_nextToCnt;

  logic [1:0]  w_req;
  logic        w_pickIdx;
  logic        w_pickAny;
  logic        w_ownBreq;
  logic        w_ownBstart;
  logic [31:0] w_ownAddr;
  logic [31:0] w_ownWdata;
  logic [1:0]  w_ownTsize;
  logic        w_ownTtype;
  logic        w_hit;

  logic        w_bgnt;
  logic        w_bdone;
  logic        w_berror;
  logic [31:0] w_rdata;

  assign w_req = {i_m1_breq, i_m0_breq};

  rr_pick2 u_pick (
    .i_req    (w_req),
    .i_last   (r_rrLast),
    .o_gntIdx (w_pickIdx),
    .o_any    (w_pickAny)
  );

  assign w_ownBreq   = r_owner ? i_m1_breq   : i_m0_breq;
  assign w_ownBstart = r_owner ? i_m1_bstart : i_m0_bstart;
  assign w_ownAddr   = r_owner ? i_m1_addr   : i_m0_addr;
  assign w_ownWdata  = r_owner ? i_m1_wdata  : i_m0_wdata;
  assign w_ownTsize  = r_owner ? i_m1_tsize  : i_m0_tsize;
  assign w_ownTtype  = r_owner ? i_m1_ttype  : i_m0_ttype;
  assign w_hit       = (w_ownAddr[SEL_MSB:SEL_LSB] == SLAVE_SEL);

  // Next-state logic. rr_last is only updated when ownership is given up,
  // so a transaction aborted by reset never counts as a turn.
  always_comb begin
    w_nextState  = r_state;
    w_nextOwner  = r_owner;
    w_nextRrLast = r_rrLast;
    w_nextToCnt  = r_toCnt;
    case (r_state)
      IDLE: begin
        if (w_pickAny) begin
          w_nextState = GRANTED;
          w_nextOwner = w_pickIdx;
        end
      end
      GRANTED: begin
        if (w_ownBstart) begin
          w_nextState = BUSY;
          w_nextToCnt = '0;
        end else if (!w_ownBreq) begin
          w_nextState  = IDLE;
          w_nextRrLast = r_owner;
        end
      end
      BUSY: begin
        if (!w_hit) begin
          w_nextState = ERR;
        end else if (i_s0_bdone) begin
          w_nextState  = IDLE;
          w_nextRrLast = r_owner;
        end else if (r_toCnt >= TO_LAST) begin
          w_nextState = ERR;
        end else if (r_toCnt != '1) begin
          w_nextToCnt = r_toCnt + TO_W'(1);
        end
      end
      ERR: begin
        w_nextState  = IDLE;
        w_nextRrLast = r_owner;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_rrLast <= 1'b1;
      r_toCnt  <= '0;
    end else begin
      r_state  <= w_nextState;
      r_owner  <= w_nextOwner;
      r_rrLast <= w_nextRrLast;
      r_toCnt  <= w_nextToCnt;
    end
  end

  // Bus muxing. Everything is decoded from registered state, so reset
  // clears the grant and slave select immediately. The slave only sees the
  // owner's bstart while busy, and slave bdone/rdata only pass through on
  // a decode hit.
  always_comb begin
    o_s0_ss     = 1'b0;
    o_s0_bstart = 1'b0;
    o_s0_addr   = i_m0_addr;
    o_s0_wdata  = i_m0_wdata;
    o_s0_tsize  = i_m0_tsize;
    o_s0_ttype  = i_m0_ttype;
    w_bgnt      = 1'b0;
    w_bdone     = 1'b0;
    w_berror    = 1'b0;
    w_rdata     = 32'h0;
    if (r_state != IDLE) begin
      o_s0_addr  = w_ownAddr;
      o_s0_wdata = w_ownWdata;
      o_s0_tsize = w_ownTsize;
      o_s0_ttype = w_ownTtype;
      w_bgnt     = 1'b1;
    end
    case (r_state)
      BUSY: begin
        o_s0_ss     = w_hit;
        o_s0_bstart = w_ownBstart;
        if (w_hit) begin
          w_bdone = i_s0_bdone;
          w_rdata = i_s0_rdata;
        end
      end
      ERR: begin
        w_bdone  = 1'b1;
        w_berror = 1'b1;
      end
      default: begin
      end
    endcase
    o_m0_bgnt   = w_bgnt   & ~r_owner;
    o_m0_bdone  = w_bdone  & ~r_owner;
    o_m0_berror = w_berror & ~r_owner;
    o_m0_rdata  = r_owner ? 32'h0 : w_rdata;
    o_m1_bgnt   = w_bgnt   & r_owner;
    o_m1_bdone  = w_bdone  & r_owner;
    o_m1_berror = w_berror & r_owner;
    o_m1_rdata  = r_owner ? w_rdata : 32'h0;
  end

endmodule

// File: tb/tb_bus_arbiter_2m1s.sv
// tb_bus_arbiter_2m1s: directed stimulus with a bdone-driven scoreboard
// for bus_arbiter_2m1s (TIMEOUT_CYC=8).
module tb_bus_arbiter_2m1s;
  import bus_pkg::*;

  localparam int HIT = 0;
  localparam int MISS = 1;
  localparam int TMO = 2;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mBreq, mBstart, mTtype;
  logic [31:0] mAddr [2];
  logic [31:0] mWdata [2];
  logic [1:0]  mTsize [2];
  logic [1:0]  mBgnt, mBdone, mBerror;
  logic [31:0] mRdata [2];
  logic        s0Ss, s0Bstart, s0Ttype, s0Bdone;
  logic [31:0] s0Addr, s0Wdata, s0Rdata;
  logic [1:0]  s0Tsize;

  int   vecCount = 0;
  int   missCount = 0;
  exp_t expQ [$];

  bus_arbiter_2m1s #(.SLAVE_SEL(4'hF), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_m0_breq   (mBreq[0]),
    .i_m0_bstart (mBstart[0]),
    .i_m0_addr   (mAddr[0]),
    .i_m0_wdata  (mWdata[0]),
    .i_m0_tsize  (mTsize[0]),
    .i_m0_ttype  (mTtype[0]),
    .o_m0_bgnt   (mBgnt[0]),
    .o_m0_bdone  (mBdone[0]),
    .o_m0_berror (mBerror[0]),
    .o_m0_rdata  (mRdata[0]),
    .i_m1_breq   (mBreq[1]),
    .i_m1_bstart (mBstart[1]),
    .i_m1_addr   (mAddr[1]),
    .i_m1_wdata  (mWdata[1]),
    .i_m1_tsize  (mTsize[1]),
    .i_m1_ttype  (mTtype[1]),
    .o_m1_bgnt   (mBgnt[1]),
    .o_m1_bdone  (mBdone[1]),
    .o_m1_berror (mBerror[1]),
    .o_m1_rdata  (mRdata[1]),
    .o_s0_ss     (s0Ss),
    .o_s0_bstart (s0Bstart),
    .o_s0_addr   (s0Addr),
    .o_s0_wdata  (s0Wdata),
    .o_s0_tsize  (s0Tsize),
    .o_s0_ttype  (s0Ttype),
    .i_s0_bdone  (s0Bdone),
    .i_s0_rdata  (s0Rdata)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    mBreq   = 2'b00;
    mBstart = 2'b00;
    mTtype  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mAddr[i]  = 32'h0;
      mWdata[i] = 32'h0;
      mTsize[i] = SZ_WORD;
    end
    s0Bdone = 1'b0;
    s0Rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One transaction by whichever master the arbiter grants; called in IDLE
  // with the request(s) already raised. The expected completion is queued
  // for the monitor.
  task automatic applyStimulus(input int expOwner, input logic [31:0] addr, input int mode,
                               input int delay, input logic [31:0] rdata);
    int waited = 0;
    int o;
    int n;
    while (mBgnt == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("grantLatency", 32'(waited), 32'd1);
    o = mBgnt[1] ? 1 : 0;
    checkOutput("grantOwner", 32'(o), 32'(expOwner));
    if (mBgnt == 2'b00) return;
    mAddr[o]   = addr;
    mWdata[o]  = ~addr;
    mTtype[o]  = READ;
    mBstart[o] = 1'b1;
    if (mode == HIT) expQ.push_back('{o, 1'b0, rdata});
    else             expQ.push_back('{o, 1'b1, 32'h0});
    tick();
    mBstart[o] = 1'b0;
    checkOutput("s0Addr", s0Addr, addr);
    checkOutput("s0Ss", 32'(s0Ss), (mode == MISS) ? 32'd0 : 32'd1);
    case (mode)
      HIT: begin
        repeat (delay - 1) tick();
        s0Bdone = 1'b1;
        s0Rdata = rdata;
        tick();
        s0Bdone = 1'b0;
        s0Rdata = 32'h0;
        checkOutput("idleGapBgnt", 32'(mBgnt), 32'd0);
      end
      MISS: begin
        tick();
        checkOutput("missSsErr", 32'(s0Ss), 32'd0);
        tick();
        checkOutput("missBdoneOnce", 32'(mBdone), 32'd0);
      end
      default: begin
        n = 1;
        while (!mBdone[o] && n < 30) begin
          tick();
          n++;
        end
        checkOutput("timeoutCycle", 32'(n), 32'd9);
        tick();
      end
    endcase
  endtask

  // Scoreboard monitor: every bdone pops one expected completion.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (mBdone != 2'b00) begin
        idx = mBdone[1] ? 1 : 0;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBdone", 32'(mBdone), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sbOwner", 32'(idx), 32'(e.idx));
          checkOutput("sbOtherBdone", 32'(mBdone[1-idx]), 32'd0);
          checkOutput("sbBerror", 32'(mBerror[idx]), 32'(e.err));
          checkOutput("sbRdata", mRdata[idx], e.rdata);
          checkOutput("sbOtherQuiet", 32'({mBgnt[1-idx], mBerror[1-idx]}), 32'd0);
          checkOutput("sbOtherRdata", mRdata[1-idx], 32'h0);
        end
      end
    end
  end

  // Hard time limit.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    doReset();
    checkOutput("rstBgnt", 32'(mBgnt), 32'd0);
    checkOutput("rstBdoneBerror", 32'({mBdone, mBerror}), 32'd0);
    checkOutput("rstRdata0", mRdata[0], 32'h0);
    checkOutput("rstRdata1", mRdata[1], 32'h0);
    checkOutput("rstSlave", 32'({s0Ss, s0Bstart}), 32'd0);

    // Single m0 read, slave answers in the third busy cycle.
    mBreq[0] = 1'b1;
    applyStimulus(0, 32'hF000_0010, HIT, 3, 32'h1234_5678);
    mBreq[0] = 1'b0;

    // Both masters request from reset and keep requesting: strict alternation.
    doReset();
    mBreq = 2'b11;
    applyStimulus(0, 32'hF000_0100, HIT, 2, 32'hAAAA_0001);
    applyStimulus(1, 32'hF000_0104, HIT, 2, 32'hBBBB_0002);
    applyStimulus(0, 32'hF000_0108, HIT, 1, 32'hAAAA_0003);
    applyStimulus(1, 32'hF000_010C, HIT, 4, 32'hBBBB_0004);
    mBreq = 2'b00;

    // Decode miss on m1.
    mBreq[1] = 1'b1;
    applyStimulus(1, 32'h1000_0000, MISS, 0, 32'h0);
    mBreq[1] = 1'b0;

    // Timeout on m0 with m1 waiting; m1 is served next.
    mBreq = 2'b11;
    applyStimulus(0, 32'hF000_0200, TMO, 0, 32'h0);
    applyStimulus(1, 32'hF000_0300, HIT, 1, 32'hCAFE_0001);
    mBreq = 2'b00;

    // Slave bdone while idle must not reach either master.
    s0Bdone = 1'b1;
    s0Rdata = 32'hDEAD_BEEF;
    #2;
    checkOutput("idleSlaveBdone", 32'(mBdone), 32'd0);
    checkOutput("idleSlaveRdata", mRdata[0], 32'h0);
    tick();
    s0Bdone = 1'b0;
    s0Rdata = 32'h0;

    // m1 gives up its grant before bstart.
    mBreq[1] = 1'b1;
    tick();
    checkOutput("grantedOwner", 32'(mBgnt), 32'd2);
    mBreq[1] = 1'b0;
    checkOutput("grantedNoBstart", 32'(s0Bstart), 32'd0);
    tick();
    checkOutput("grantReleased", 32'(mBgnt), 32'd0);
    checkOutput("releasedNoBstart", 32'(s0Bstart), 32'd0);

    // m0 completes (m1 would now win a tie), then reset mid-transfer.
    mBreq[0] = 1'b1;
    applyStimulus(0, 32'hF000_0400, HIT, 2, 32'h0BAD_F00D);
    tick();
    checkOutput("abortGrant", 32'(mBgnt), 32'd1);
    mAddr[0]   = 32'hF000_0500;
    mBstart[0] = 1'b1;
    tick();
    mBstart[0] = 1'b0;
    checkOutput("abortBusySs", 32'(s0Ss), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBgnt", 32'(mBgnt), 32'd0);
    checkOutput("asyncRstSs", 32'(s0Ss), 32'd0);
    mBreq = 2'b11;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("postResetOwner", 32'(mBgnt), 32'd1);
    mBreq = 2'b00;
    repeat (3) tick();
    checkOutput("sbDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
